// File: rtl/bnn_cfg_pkg.sv
// Shared constants for the BNN weight/bias configuration loader: frame
// lengths, header codes, power-on weight set, payload field offsets and
// the loader FSM state codes.
package bnn_cfg_pkg;

   localparam int HDR_BITS         = 8;
   localparam int PAYLOAD_BITS     = 40;
   localparam int CSUM_BITS        = 8;
   localparam int WRITE_FRAME_BITS = 56;
   localparam int READ_BITS        = 48;

   localparam logic [7:0] HDR_WRITE_CODE = 8'hA5;
   localparam logic [7:0] HDR_READ_CODE  = 8'h5A;

   // w_ih0..3 = 1001,1011,1100,1110; w_ho0/1 = 1010,0101; biases +1,+1,-1,+1
   localparam logic [39:0] DEFAULT_PAYLOAD = 40'h9B_CE_A5_11_F1;

   // Bit offsets of each 4-bit field inside the 40-bit payload (MSB first on the wire)
   localparam int OFS_W_IH0  = 36;
   localparam int OFS_W_IH1  = 32;
   localparam int OFS_W_IH2  = 28;
   localparam int OFS_W_IH3  = 24;
   localparam int OFS_W_HO0  = 20;
   localparam int OFS_W_HO1  = 16;
   localparam int OFS_BIAS_H0 = 12;
   localparam int OFS_BIAS_H1 = 8;
   localparam int OFS_BIAS_H2 = 4;
   localparam int OFS_BIAS_H3 = 0;

   // Loader FSM state codes
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR     = 3'd1;
   localparam logic [2:0] ST_WR_DATA = 3'd2;
   localparam logic [2:0] ST_WR_CSUM = 3'd3;
   localparam logic [2:0] ST_RD_DATA = 3'd4;
   localparam logic [2:0] ST_DRAIN   = 3'd5;

   // Frame checksum: XOR of the five payload bytes
   function automatic logic [7:0] payload_csum(input logic [39:0] p);
      return p[39:32] ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
   endfunction

endpackage

// File: rtl/cfg_pin_sync.sv
// Multi-stage synchronizer for the three asynchronous config pins, plus
// single-cycle edge strobes for sck and cs_n taken after the last stage.
// Requires SYNC_STAGES >= 2.
module cfg_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cs_n_pin,
   input  logic sck_pin,
   input  logic sdi_pin,
   output logic cs_n,
   output logic sdi,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_rise,
   output logic cs_fall
);

   logic [SYNC_STAGES-1:0] cs_ff;
   logic [SYNC_STAGES-1:0] sck_ff;
   logic [SYNC_STAGES-1:0] sdi_ff;
   logic                   cs_prev;
   logic                   sck_prev;

   // Shift each pin through the synchronizer chain; keep the previous synced level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_ff    <= '1;
         sck_ff   <= '0;
         sdi_ff   <= '0;
         cs_prev  <= 1'b1;
         sck_prev <= 1'b0;
      end else begin
         cs_ff    <= {cs_ff[SYNC_STAGES-2:0], cs_n_pin};
         sck_ff   <= {sck_ff[SYNC_STAGES-2:0], sck_pin};
         sdi_ff   <= {sdi_ff[SYNC_STAGES-2:0], sdi_pin};
         cs_prev  <= cs_ff[SYNC_STAGES-1];
         sck_prev <= sck_ff[SYNC_STAGES-1];
      end
   end

   assign cs_n     = cs_ff[SYNC_STAGES-1];
   assign sdi      = sdi_ff[SYNC_STAGES-1];
   assign sck_rise =  sck_ff[SYNC_STAGES-1] & ~sck_prev;
   assign sck_fall = ~sck_ff[SYNC_STAGES-1] &  sck_prev;
   assign cs_rise  =  cs_ff[SYNC_STAGES-1]  & ~cs_prev;
   assign cs_fall  = ~cs_ff[SYNC_STAGES-1]  &  cs_prev;

endmodule

// File: rtl/bnn_weight_loader.sv
// Serial configuration writer for the BNN classifier weights/biases.
// A frame is shifted in over a 3-wire SPI-mode-0 link, checksum-verified,
// staged, and committed atomically to the active set only while the
// classifier reports IDLE. A read frame streams the active set back out.
module bnn_weight_loader
   import bnn_cfg_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] HDR_WRITE   = HDR_WRITE_CODE,
   parameter logic [7:0] HDR_READ    = HDR_READ_CODE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_cs_n,
   input  logic              cfg_sck,
   input  logic              cfg_sdi,
   output logic              cfg_sdo,
   input  logic              cls_idle,
   output logic        [3:0] w_ih0,
   output logic        [3:0] w_ih1,
   output logic        [3:0] w_ih2,
   output logic        [3:0] w_ih3,
   output logic        [3:0] w_ho0,
   output logic        [3:0] w_ho1,
   output logic signed [3:0] bias_h0,
   output logic signed [3:0] bias_h1,
   output logic signed [3:0] bias_h2,
   output logic signed [3:0] bias_h3,
   output logic              cfg_pending,
   output logic              commit_pulse,
   output logic              cfg_err,
   output logic              cfg_busy,
   output logic        [2:0] dbg_state
);

   logic        cs_n_s, sdi_s, sck_rise, sck_fall, cs_rise, cs_fall;
   logic [2:0]  state;
   logic [5:0]  bit_cnt;
   logic [47:0] shreg;
   logic [47:0] rd_sh;
   logic [39:0] staged;
   logic [39:0] active;
   logic [47:0] shreg_next;
   logic [47:0] rd_word;
   logic        csum_ok;

   cfg_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .cs_n_pin (cfg_cs_n),
      .sck_pin  (cfg_sck),
      .sdi_pin  (cfg_sdi),
      .cs_n     (cs_n_s),
      .sdi      (sdi_s),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .cs_rise  (cs_rise),
      .cs_fall  (cs_fall)
   );

   // Header and write bits share one shift register; after a full write
   // frame the header has been shifted out and it holds payload + checksum.
   assign shreg_next = {shreg[46:0], sdi_s};
   assign csum_ok    = (shreg_next[7:0] == payload_csum(shreg_next[47:8]));
   assign rd_word    = {active, payload_csum(active)};

   // Frame FSM, staging, commit and readback shifter (commit and validation may share a cycle)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         rd_sh        <= '0;
         staged       <= DEFAULT_PAYLOAD;
         active       <= DEFAULT_PAYLOAD;
         cfg_sdo      <= 1'b0;
         cfg_pending  <= 1'b0;
         commit_pulse <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         commit_pulse <= 1'b0;
         if (cfg_pending && cls_idle) begin
            active       <= staged;
            commit_pulse <= 1'b1;
            cfg_pending  <= 1'b0;
         end
         if (cs_rise) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            cfg_sdo <= 1'b0;
            if (state == ST_HDR || state == ST_WR_DATA || state == ST_WR_CSUM)
               cfg_err <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state   <= ST_HDR;
                     cfg_err <= 1'b0;
                     bit_cnt <= '0;
                  end
               end
               ST_HDR: begin
                  if (sck_rise) begin
                     shreg   <= shreg_next;
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'(HDR_BITS - 1)) begin
                        bit_cnt <= '0;
                        if (shreg_next[7:0] == HDR_WRITE) begin
                           state <= ST_WR_DATA;
                        end else if (shreg_next[7:0] == HDR_READ) begin
                           state   <= ST_RD_DATA;
                           cfg_sdo <= rd_word[47];
                           rd_sh   <= {rd_word[46:0], 1'b0};
                        end else begin
                           cfg_err <= 1'b1;
                           state   <= ST_DRAIN;
                        end
                     end
                  end
               end
               ST_WR_DATA: begin
                  if (sck_rise) begin
                     shreg   <= shreg_next;
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'(PAYLOAD_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= ST_WR_CSUM;
                     end
                  end
               end
               ST_WR_CSUM: begin
                  if (sck_rise) begin
                     shreg   <= shreg_next;
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'(CSUM_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= ST_DRAIN;
                        if (csum_ok) begin
                           staged      <= shreg_next[47:8];
                           cfg_pending <= 1'b1;
                        end else begin
                           cfg_err <= 1'b1;
                        end
                     end
                  end
               end
               ST_RD_DATA: begin
                  // The first falling edge follows the last header bit; bit 1 is already out, so hold it
                  if (sck_fall) begin
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt != 6'd0) begin
                        cfg_sdo <= rd_sh[47];
                        rd_sh   <= {rd_sh[46:0], 1'b0};
                     end
                     if (bit_cnt == 6'(READ_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= ST_DRAIN;
                     end
                  end
               end
               ST_DRAIN: begin
                  if (sck_fall) cfg_sdo <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign w_ih0   = active[OFS_W_IH0 +: 4];
   assign w_ih1   = active[OFS_W_IH1 +: 4];
   assign w_ih2   = active[OFS_W_IH2 +: 4];
   assign w_ih3   = active[OFS_W_IH3 +: 4];
   assign w_ho0   = active[OFS_W_HO0 +: 4];
   assign w_ho1   = active[OFS_W_HO1 +: 4];
   assign bias_h0 = active[OFS_BIAS_H0 +: 4];
   assign bias_h1 = active[OFS_BIAS_H1 +: 4];
   assign bias_h2 = active[OFS_BIAS_H2 +: 4];
   assign bias_h3 = active[OFS_BIAS_H3 +: 4];

   assign cfg_busy  = ~cs_n_s;
   assign dbg_state = state;

endmodule

// File: tb/tb_bnn_weight_loader.sv
// Self-checking bench for bnn_weight_loader: directed scenarios followed by
// randomized frames, compared against a frame-level reference model.
module tb_bnn_weight_loader;
   import bnn_cfg_pkg::*;

   localparam int HALF = 6;  // sck phase length in clk periods

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfg_cs_n = 1'b1;
   logic cfg_sck = 1'b0;
   logic cfg_sdi = 1'b0;
   logic cls_idle = 1'b0;
   logic cfg_sdo;
   logic [3:0] w_ih0, w_ih1, w_ih2, w_ih3, w_ho0, w_ho1;
   logic signed [3:0] bias_h0, bias_h1, bias_h2, bias_h3;
   logic cfg_pending, commit_pulse, cfg_err, cfg_busy;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   logic [47:0] exp_q[$];

   // reference model state
   logic [39:0] m_active, m_staged;
   logic        m_pending, m_err;
   int          m_pulses;

   // clock / reset block
   always #5 clk = ~clk;

   bnn_weight_loader dut (
      .clk(clk), .rst_n(rst_n), .cfg_cs_n(cfg_cs_n), .cfg_sck(cfg_sck),
      .cfg_sdi(cfg_sdi), .cfg_sdo(cfg_sdo), .cls_idle(cls_idle),
      .w_ih0(w_ih0), .w_ih1(w_ih1), .w_ih2(w_ih2), .w_ih3(w_ih3),
      .w_ho0(w_ho0), .w_ho1(w_ho1),
      .bias_h0(bias_h0), .bias_h1(bias_h1), .bias_h2(bias_h2), .bias_h3(bias_h3),
      .cfg_pending(cfg_pending), .commit_pulse(commit_pulse), .cfg_err(cfg_err),
      .cfg_busy(cfg_busy), .dbg_state(dbg_state)
   );

   always @(negedge clk) if (commit_pulse) pulses++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_csum(input logic [39:0] p);
      logic [7:0] c = 8'h00;
      for (int i = 0; i < 5; i++) c ^= p[i*8 +: 8];
      return c;
   endfunction

   function automatic logic [39:0] dut_active();
      return {w_ih0, w_ih1, w_ih2, w_ih3, w_ho0, w_ho1,
              bias_h0, bias_h1, bias_h2, bias_h3};
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one serial bit; optionally strobe cls_idle on the cycle the rising edge is acted upon
   task automatic spi_bit(input logic b, input logic idle_pulse, output logic rx);
      cfg_sdi = b;
      wait_clk(HALF);
      rx = cfg_sdo;
      cfg_sck = 1'b1;
      if (idle_pulse) begin
         wait_clk(2);
         cls_idle = 1'b1;
         wait_clk(1);
         cls_idle = 1'b0;
         wait_clk(HALF - 3);
      end else begin
         wait_clk(HALF);
      end
      cfg_sck = 1'b0;
   endtask

   task automatic frame(input logic [55:0] bits, input int nbits, input int idle_at,
                        input logic chk_clear, output logic [47:0] rx);
      logic r;
      rx = '0;
      cfg_cs_n = 1'b0;
      wait_clk(HALF);
      if (chk_clear) begin
         check("err_clear_on_cs_fall", 64'(cfg_err), 64'(0));
         check("busy_in_frame", 64'(cfg_busy), 64'(1));
      end
      for (int i = 0; i < nbits; i++) begin
         spi_bit(bits[55-i], i == idle_at, r);
         if (i >= 8) rx = {rx[46:0], r};
      end
      wait_clk(HALF);
      cfg_cs_n = 1'b1;
      cfg_sdi = 1'b0;
      wait_clk(8);
   endtask

   // frame-level reference behaviour
   task automatic model_frame(input logic [55:0] bits, input int nbits);
      logic [7:0] hdr;
      hdr = bits[55:48];
      if (nbits < 8) m_err = 1'b1;
      else if (hdr == 8'hA5) begin
         if (nbits < 56) m_err = 1'b1;
         else if (bits[7:0] == ref_csum(bits[47:8])) begin
            m_err = 1'b0;
            m_staged = bits[47:8];
            m_pending = 1'b1;
         end else m_err = 1'b1;
      end else if (hdr == 8'h5A) m_err = 1'b0;
      else m_err = 1'b1;
   endtask

   task automatic model_idle();
      if (m_pending) begin
         m_active = m_staged;
         m_pending = 1'b0;
         m_pulses++;
      end
   endtask

   task automatic model_reset();
      m_active = DEFAULT_PAYLOAD;
      m_staged = DEFAULT_PAYLOAD;
      m_pending = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic idle_window(input int n);
      cls_idle = 1'b1;
      wait_clk(n);
      cls_idle = 1'b0;
      wait_clk(2);
      model_idle();
   endtask

   task automatic check_state(input string tag);
      check({tag, "_active"}, 64'(dut_active()), 64'(m_active));
      check({tag, "_pending"}, 64'(cfg_pending), 64'(m_pending));
      check({tag, "_err"}, 64'(cfg_err), 64'(m_err));
      check({tag, "_pulses"}, 64'(pulses), 64'(m_pulses));
      check({tag, "_busy"}, 64'(cfg_busy), 64'(0));
      check({tag, "_sdo"}, 64'(cfg_sdo), 64'(0));
   endtask

   task automatic do_write(input logic [39:0] p, input logic [7:0] cs, input int nbits,
                           input int idle_at, input logic chk_clear);
      logic [55:0] bits;
      logic [47:0] rx;
      bits = {8'hA5, p, cs};
      frame(bits, nbits, idle_at, chk_clear, rx);
      if (idle_at >= 0) model_idle();
      model_frame(bits, nbits);
   endtask

   task automatic do_read(input logic chk_clear);
      logic [55:0] bits;
      logic [47:0] rx;
      bits = {8'h5A, 48'h0};
      exp_q.push_back({m_active, ref_csum(m_active)});
      frame(bits, 56, -1, chk_clear, rx);
      check("readback", 64'(rx), 64'(exp_q.pop_front()));
      model_frame(bits, 56);
   endtask

   task automatic do_bad_header(input logic [7:0] hdr);
      logic [55:0] bits;
      logic [47:0] rx;
      bits = {hdr, 48'(({$urandom, $urandom}))};
      frame(bits, 56, -1, 1'b0, rx);
      model_frame(bits, 56);
   endtask

   task automatic report();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
   endtask

   // watchdog
   initial begin
      repeat (60000) @(posedge clk);
      errors++;
      $display("FAIL watchdog: cycle budget expired before completion");
      report();
      $finish;
   end

   initial begin
      logic [39:0] p, pa, pb;
      logic [7:0]  h;
      logic        r;
      int          kind;

      model_reset();
      m_pulses = 0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);

      // reset values and default readback
      check_state("reset");
      check("reset_dbg_state", 64'(dbg_state), 64'(ST_IDLE));
      check("default_payload", 64'(m_active), 64'(40'h9BCEA511F1));
      do_read(1'b0);
      check_state("after_read0");

      // all-zero write held off by cls_idle = 0, then committed
      do_write(40'h0, 8'h00, 56, -1, 1'b0);
      check_state("zero_staged");
      check("zero_outputs_unchanged", 64'(dut_active()), 64'(DEFAULT_PAYLOAD));
      idle_window(4);
      check_state("zero_commit");
      do_read(1'b0);

      // wrong checksum
      do_write(40'h0, 8'hFF, 56, -1, 1'b0);
      check_state("bad_csum");
      do_read(1'b1);
      check_state("err_cleared");

      // abort after 30 bits, then bad header
      p = {8'($urandom), 32'($urandom)};
      do_write(p, ref_csum(p), 30, -1, 1'b0);
      check_state("abort30");
      check("abort_dbg_state", 64'(dbg_state), 64'(ST_IDLE));
      do_bad_header(8'h33);
      check_state("hdr33");
      idle_window(3);
      check_state("hdr33_idle");

      // back-to-back: second validated on the same cycle as commit of first
      pa = {8'($urandom), 32'($urandom)};
      pb = {8'($urandom), 32'($urandom)};
      do_write(pa, ref_csum(pa), 56, -1, 1'b0);
      check_state("b2b_first");
      do_write(pb, ref_csum(pb), 56, 55, 1'b0);
      check_state("b2b_same_cycle");
      check("b2b_active_is_first", 64'(dut_active()), 64'(pa));
      idle_window(3);
      check_state("b2b_second_commit");
      check("b2b_active_is_second", 64'(dut_active()), 64'(pb));

      // reset during WR_DATA with a pending set
      p = {8'($urandom), 32'($urandom)};
      do_write(p, ref_csum(p), 56, -1, 1'b0);
      check_state("pre_reset_pending");
      cfg_cs_n = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < 20; i++) spi_bit(1'(i % 3 == 0), 1'b0, r);
      rst_n = 1'b0;
      cfg_cs_n = 1'b1;
      cfg_sdi = 1'b0;
      #1;
      model_reset();
      check("rst_active_immediate", 64'(dut_active()), 64'(DEFAULT_PAYLOAD));
      check("rst_pending_immediate", 64'(cfg_pending), 64'(0));
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
      check_state("after_reset");
      p = {8'($urandom), 32'($urandom)};
      do_write(p, ref_csum(p), 56, -1, 1'b0);
      idle_window(2);
      check_state("post_reset_commit");

      // randomized frames
      for (int it = 0; it < 14; it++) begin
         kind = int'($urandom_range(0, 4));
         p = {8'($urandom), 32'($urandom)};
         case (kind)
            0: do_write(p, ref_csum(p), 56, -1, 1'($urandom_range(0, 1)));
            1: do_write(p, ref_csum(p) ^ 8'($urandom_range(1, 255)), 56, -1, 1'b0);
            2: do_write(p, ref_csum(p), int'($urandom_range(1, 55)), -1, 1'b0);
            3: begin
               h = 8'($urandom);
               if (h == 8'hA5 || h == 8'h5A) h = 8'h00;
               do_bad_header(h);
            end
            default: do_read(1'b1);
         endcase
         check_state("rand_frame");
         if ($urandom_range(0, 1) == 1) begin
            idle_window(int'($urandom_range(1, 4)));
            check_state("rand_idle");
         end
      end
      do_read(1'b0);

      report();
      $finish;
   end

endmodule
